bios_boot_rom: RTL and testbench

//  Parametrised boot ROM with registered CPU fetch port and a boot-copy engine.

---
 rtl/bios_boot_rom_pkg.sv | 23 ++
 rtl/bios_boot_rom_rom.sv | 70 +++++++
 rtl/bios_boot_rom.sv | 185 ++++++++++++++++++
 tb/tb_bios_boot_rom.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bios_boot_rom_pkg.sv
// Shared definitions for the BIOS boot ROM slice.
// Holds the copy-engine state encoding, the HALT opcode that is returned
// for fetches beyond the image, and a helper that sizes the word index.
package bios_boot_rom_pkg;

  // Copy-engine states, 2-bit encoding shared by every user of the package.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } bootState_e;

  // Top six bits of an instruction word that the CPU decodes as HALT.
  localparam logic [5:0] OPCODE_HALT = 6'b111111;

  // Width of a word index into a ROM of the given depth, never below 1 bit
  // so that a single-word image still has a legal counter.
  function automatic int unsigned idxWidth(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bios_boot_rom_rom.sv
// BIOS image storage with two independent registered read ports.
// The fetch port serves the CPU and can substitute a HALT word when the
// requested address lies outside the image; the copy port feeds the boot
// copy engine. Both output registers clear on reset and hold their value
// whenever their enable is low.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   fetch_en_i     load the fetch register this cycle
//   fetch_halt_i   load HALT instead of a ROM word
//   fetch_idx_i    word index for the fetch port
//   fetch_data_o   registered fetch word
//   copy_en_i      load the copy register this cycle
//   copy_idx_i     word index for the copy port
//   copy_data_o    registered copy word
module bios_boot_rom_rom
  import bios_boot_rom_pkg::*;
#(
  parameter int unsigned                        DATA_WIDTH = 32,
  parameter int unsigned                        BIOS_DEPTH = 64,
  parameter int unsigned                        IDX_WIDTH  = 6,
  parameter logic [BIOS_DEPTH*DATA_WIDTH-1:0]   INIT_IMAGE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_en_i,
  input  logic                  fetch_halt_i,
  input  logic [IDX_WIDTH-1:0]  fetch_idx_i,
  output logic [DATA_WIDTH-1:0] fetch_data_o,
  input  logic                  copy_en_i,
  input  logic [IDX_WIDTH-1:0]  copy_idx_i,
  output logic [DATA_WIDTH-1:0] copy_data_o
);

  localparam logic [DATA_WIDTH-1:0] HALT_WORD = {OPCODE_HALT, {(DATA_WIDTH-6){1'b0}}};

  logic [DATA_WIDTH-1:0] romMem [BIOS_DEPTH];
  logic [DATA_WIDTH-1:0] fetchData_q;
  logic [DATA_WIDTH-1:0] copyData_q;

  // Unpack the flat image parameter into word-addressable storage.
  // Word 0 sits in the least significant DATA_WIDTH bits of INIT_IMAGE.
  for (genvar i = 0; i < BIOS_DEPTH; i++) begin : g_word
    assign romMem[i] = INIT_IMAGE[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Fetch port register. When the caller flags an out-of-range address
  // the index is meaningless, so the HALT word is loaded instead.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetchData_q <= '0;
    end else if (fetch_en_i) begin
      fetchData_q <= fetch_halt_i ? HALT_WORD : romMem[fetch_idx_i];
    end
  end

  // Copy port register. It keeps its word between loads, which is what
  // holds the write data stable while the memory stalls the copy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      copyData_q <= '0;
    end else if (copy_en_i) begin
      copyData_q <= romMem[copy_idx_i];
    end
  end

  assign fetch_data_o = fetchData_q;
  assign copy_data_o  = copyData_q;

endmodule

// File: rtl/bios_boot_rom.sv
// Boot ROM with a registered CPU fetch port and a boot-copy engine.
// After reset (when COPY_ON_RESET is set) or on a boot_start pulse the
// engine streams the BIOS image into instruction memory, one word per
// READ/WRITE pair, over a mem_we/mem_ready handshake, and keeps the CPU
// stalled until the last word is accepted.
//
// Ports:
//   clock, reset    rising-edge clock, asynchronous active-high reset
//   pc              fetch address
//   fetch_en        fetch request this cycle
//   instrucao       fetched word (latency 1)
//   instr_valid     instrucao valid this cycle
//   oob_error       previous fetch had pc >= BIOS_DEPTH
//   boot_start      single-cycle request to (re)run the copy
//   mem_addr        copy write address
//   mem_wdata       copy write data
//   mem_we          copy write valid
//   mem_ready       memory accepts the write when mem_we && mem_ready
//   cpu_hold        stall the CPU
//   boot_done       copy completed
//   boot_checksum   sum of copied words modulo 2**DATA_WIDTH
module bios_boot_rom
  import bios_boot_rom_pkg::*;
#(
  parameter int unsigned                        DATA_WIDTH    = 32,
  parameter int unsigned                        ADDR_WIDTH    = 26,
  parameter int unsigned                        BIOS_DEPTH    = 64,
  parameter logic [BIOS_DEPTH*DATA_WIDTH-1:0]   INIT_IMAGE    = '0,
  parameter logic [ADDR_WIDTH-1:0]              DEST_BASE     = '0,
  parameter bit                                 COPY_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  fetch_en,
  output logic [DATA_WIDTH-1:0] instrucao,
  output logic                  instr_valid,
  output logic                  oob_error,
  input  logic                  boot_start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic                  cpu_hold,
  output logic                  boot_done,
  output logic [DATA_WIDTH-1:0] boot_checksum
);

  localparam int unsigned             IDX_WIDTH   = idxWidth(BIOS_DEPTH);
  localparam logic [IDX_WIDTH-1:0]    LAST_IDX    = IDX_WIDTH'(BIOS_DEPTH - 1);
  // One extra bit so a full 2**ADDR_WIDTH image still has a representable limit.
  localparam logic [ADDR_WIDTH:0]     DEPTH_LIMIT = (ADDR_WIDTH+1)'(BIOS_DEPTH);

  bootState_e            state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic                  memWe_q, memWe_d;
  logic                  cpuHold_q, cpuHold_d;
  logic                  bootDone_q, bootDone_d;
  logic                  afterReset_q;
  logic                  instrValid_q, instrValid_d;
  logic                  oobError_q, oobError_d;
  logic                  copyRead;
  logic                  fetchLoad;
  logic                  pcInRange;

  // Range check on the full pc so high address bits can never alias
  // back into the image.
  assign pcInRange = ({1'b0, pc} < DEPTH_LIMIT);
  assign fetchLoad = fetch_en && !cpuHold_q;

  bios_boot_rom_rom #(
    .DATA_WIDTH (DATA_WIDTH),
    .BIOS_DEPTH (BIOS_DEPTH),
    .IDX_WIDTH  (IDX_WIDTH),
    .INIT_IMAGE (INIT_IMAGE)
  ) u_rom (
    .clock        (clock),
    .reset        (reset),
    .fetch_en_i   (fetchLoad),
    .fetch_halt_i (!pcInRange),
    .fetch_idx_i  (pc[IDX_WIDTH-1:0]),
    .fetch_data_o (instrucao),
    .copy_en_i    (copyRead),
    .copy_idx_i   (idx_q),
    .copy_data_o  (mem_wdata)
  );

  // Copy-engine next state. READ latches one ROM word and raises the
  // write; WRITE waits for the memory to accept it, accumulates the
  // checksum and either advances or finishes. boot_start only matters
  // in IDLE and DONE so a running copy can never be disturbed.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    checksum_d = checksum_q;
    memAddr_d  = memAddr_q;
    memWe_d    = memWe_q;
    copyRead   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((COPY_ON_RESET && afterReset_q) || boot_start) begin
          state_d    = S_READ;
          idx_d      = '0;
          checksum_d = '0;
        end
      end
      S_READ: begin
        copyRead  = 1'b1;
        memAddr_d = DEST_BASE + ADDR_WIDTH'(idx_q);
        memWe_d   = 1'b1;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        if (mem_ready) begin
          checksum_d = checksum_q + mem_wdata;
          memWe_d    = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_WIDTH'(1);
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        if (boot_start) begin
          state_d    = S_READ;
          idx_d      = '0;
          checksum_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Status flags follow the state being entered, so cpu_hold drops in
    // IDLE after the first clock and boot_done rises with DONE.
    cpuHold_d  = (state_d == S_READ) || (state_d == S_WRITE);
    bootDone_d = (state_d == S_DONE);
  end

  // Fetch status: a fetch is only honoured while the CPU is released;
  // an out-of-range pc still produces a valid (HALT) word.
  always_comb begin
    instrValid_d = fetchLoad;
    oobError_d   = fetchLoad && !pcInRange;
  end

  // State and output registers. afterReset_q marks the first clock after
  // reset release, which is when an automatic copy is launched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      checksum_q   <= '0;
      memAddr_q    <= '0;
      memWe_q      <= 1'b0;
      cpuHold_q    <= 1'b1;
      bootDone_q   <= 1'b0;
      afterReset_q <= 1'b1;
      instrValid_q <= 1'b0;
      oobError_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      checksum_q   <= checksum_d;
      memAddr_q    <= memAddr_d;
      memWe_q      <= memWe_d;
      cpuHold_q    <= cpuHold_d;
      bootDone_q   <= bootDone_d;
      afterReset_q <= 1'b0;
      instrValid_q <= instrValid_d;
      oobError_q   <= oobError_d;
    end
  end

  assign mem_addr      = memAddr_q;
  assign mem_we        = memWe_q;
  assign cpu_hold      = cpuHold_q;
  assign boot_done     = bootDone_q;
  assign boot_checksum = checksum_q;
  assign instr_valid   = instrValid_q;
  assign oob_error     = oobError_q;

endmodule

// File: tb/tb_bios_boot_rom.sv
// Directed bench for bios_boot_rom. Instance A auto-copies a 4-word image
// to 0x10 in a 26-bit space; instance B needs boot_start and copies to 14
// in a 4-bit space so its write addresses wrap.
module tb_bios_boot_rom;

  localparam logic [31:0] IMG_A = 32'hDEAD_BEEF;
  localparam logic [31:0] IMG_B = 32'h0123_4567;
  localparam logic [31:0] IMG_C = 32'hCAFE_F00D;
  localparam logic [31:0] IMG_D = 32'h8000_0001;
  localparam logic [31:0] SUM_ALL = 32'h2ACF_F464;
  localparam logic [31:0] HALT    = 32'hFC00_0000;

  logic        clock;
  logic        reset;

  logic [25:0] pcA;
  logic        fetchEnA, bootStartA, memReadyA;
  logic [31:0] instrA, memWdataA, checksumA;
  logic [25:0] memAddrA;
  logic        instrValidA, oobA, memWeA, cpuHoldA, bootDoneA;

  logic [3:0]  pcB;
  logic        fetchEnB, bootStartB, memReadyB;
  logic [31:0] instrB, memWdataB, checksumB;
  logic [3:0]  memAddrB;
  logic        instrValidB, oobB, memWeB, cpuHoldB, bootDoneB;

  int vectors = 0;
  int miscompares = 0;
  int acceptsA = 0;
  int acceptBase;

  logic [31:0] img [4];
  logic [31:0] partSum [4];
  logic [3:0]  addrSeqB [4];

  bios_boot_rom #(
    .DATA_WIDTH(32), .ADDR_WIDTH(26), .BIOS_DEPTH(4),
    .INIT_IMAGE({IMG_D, IMG_C, IMG_B, IMG_A}),
    .DEST_BASE(26'h10), .COPY_ON_RESET(1'b1)
  ) dutA (
    .clock(clock), .reset(reset), .pc(pcA), .fetch_en(fetchEnA),
    .instrucao(instrA), .instr_valid(instrValidA), .oob_error(oobA),
    .boot_start(bootStartA), .mem_addr(memAddrA), .mem_wdata(memWdataA),
    .mem_we(memWeA), .mem_ready(memReadyA), .cpu_hold(cpuHoldA),
    .boot_done(bootDoneA), .boot_checksum(checksumA)
  );

  bios_boot_rom #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .BIOS_DEPTH(4),
    .INIT_IMAGE({IMG_D, IMG_C, IMG_B, IMG_A}),
    .DEST_BASE(4'd14), .COPY_ON_RESET(1'b0)
  ) dutB (
    .clock(clock), .reset(reset), .pc(pcB), .fetch_en(fetchEnB),
    .instrucao(instrB), .instr_valid(instrValidB), .oob_error(oobB),
    .boot_start(bootStartB), .mem_addr(memAddrB), .mem_wdata(memWdataB),
    .mem_we(memWeB), .mem_ready(memReadyB), .cpu_hold(cpuHoldB),
    .boot_done(bootDoneB), .boot_checksum(checksumB)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count writes accepted by memory A.
  always @(posedge clock) begin
    if (memWeA && memReadyA) acceptsA <= acceptsA + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic fe, input logic [25:0] p,
                               input logic bs, input logic rdy);
    fetchEnA   = fe;
    pcA        = p;
    bootStartA = bs;
    memReadyA  = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitDoneA(input int budget);
    int n = 0;
    while (!bootDoneA && n < budget) begin
      tick();
      n++;
    end
    checkOutput("A done within budget", 64'(bootDoneA), 64'd1);
  endtask

  initial begin
    img      = '{IMG_A, IMG_B, IMG_C, IMG_D};
    partSum  = '{32'hDEAD_BEEF, 32'hDFD1_0456, 32'hAACF_F463, SUM_ALL};
    addrSeqB = '{4'd14, 4'd15, 4'd0, 4'd1};
    reset = 1'b1;
    applyStimulus(1'b0, 26'd0, 1'b0, 1'b1);
    fetchEnB = 1'b0; pcB = 4'd0; bootStartB = 1'b0; memReadyB = 1'b1;

    // Reset values.
    tick(); tick();
    checkOutput("rst instrucao",   64'(instrA),      64'd0);
    checkOutput("rst instr_valid", 64'(instrValidA), 64'd0);
    checkOutput("rst oob_error",   64'(oobA),        64'd0);
    checkOutput("rst mem_we",      64'(memWeA),      64'd0);
    checkOutput("rst mem_addr",    64'(memAddrA),    64'd0);
    checkOutput("rst mem_wdata",   64'(memWdataA),   64'd0);
    checkOutput("rst boot_done",   64'(bootDoneA),   64'd0);
    checkOutput("rst checksum",    64'(checksumA),   64'd0);
    checkOutput("rst cpu_hold",    64'(cpuHoldA),    64'd1);
    checkOutput("rst B cpu_hold",  64'(cpuHoldB),    64'd1);

    // Release: A enters READ on the first clock, B stays idle and frees the CPU.
    reset = 1'b0;
    tick();
    checkOutput("A first READ mem_we", 64'(memWeA),   64'd0);
    checkOutput("A first READ hold",   64'(cpuHoldA), 64'd1);
    checkOutput("B idle hold",         64'(cpuHoldB), 64'd0);
    checkOutput("B idle mem_we",       64'(memWeB),   64'd0);

    // Auto copy, one word per two cycles, done on the 9th clock.
    for (int w = 0; w < 4; w++) begin
      tick();
      checkOutput($sformatf("A write%0d we", w),   64'(memWeA),    64'd1);
      checkOutput($sformatf("A write%0d addr", w), 64'(memAddrA),  64'(16 + w));
      checkOutput($sformatf("A write%0d data", w), 64'(memWdataA), 64'(img[w]));
      checkOutput($sformatf("A write%0d done", w), 64'(bootDoneA), 64'd0);
      tick();
      checkOutput($sformatf("A accept%0d sum", w), 64'(checksumA), 64'(partSum[w]));
      if (w < 3) checkOutput($sformatf("A accept%0d we", w), 64'(memWeA), 64'd0);
    end
    checkOutput("A done at 9",      64'(bootDoneA), 64'd1);
    checkOutput("A hold released",  64'(cpuHoldA),  64'd0);
    checkOutput("A accepts",        64'(acceptsA),  64'd4);
    checkOutput("B still idle",     64'(bootDoneB), 64'd0);

    // Fetch path including out-of-range and high-bit aliasing addresses.
    applyStimulus(1'b1, 26'd2, 1'b0, 1'b1);
    tick();
    checkOutput("fetch pc2 instr", 64'(instrA),      64'(IMG_C));
    checkOutput("fetch pc2 valid", 64'(instrValidA), 64'd1);
    checkOutput("fetch pc2 oob",   64'(oobA),        64'd0);
    pcA = 26'd4;
    tick();
    checkOutput("fetch pc4 instr", 64'(instrA),      64'(HALT));
    checkOutput("fetch pc4 valid", 64'(instrValidA), 64'd1);
    checkOutput("fetch pc4 oob",   64'(oobA),        64'd1);
    pcA = 26'h100_0002;
    tick();
    checkOutput("fetch alias instr", 64'(instrA), 64'(HALT));
    checkOutput("fetch alias oob",   64'(oobA),   64'd1);
    pcA = 26'd3;
    tick();
    checkOutput("fetch pc3 instr", 64'(instrA), 64'(IMG_D));
    checkOutput("fetch pc3 oob",   64'(oobA),   64'd0);
    fetchEnA = 1'b0;
    tick();
    checkOutput("idle fetch valid", 64'(instrValidA), 64'd0);
    checkOutput("idle fetch oob",   64'(oobA),        64'd0);
    checkOutput("idle fetch hold",  64'(instrA),      64'(IMG_D));

    // Recopy from DONE, boot_start ignored in WRITE, stall on word 2.
    acceptBase = acceptsA;
    bootStartA = 1'b1;
    tick();
    bootStartA = 1'b0;
    checkOutput("recopy done drop", 64'(bootDoneA), 64'd0);
    checkOutput("recopy sum clear", 64'(checksumA), 64'd0);
    checkOutput("recopy hold",      64'(cpuHoldA),  64'd1);
    tick();
    checkOutput("recopy w0 addr", 64'(memAddrA), 64'h10);
    tick(); tick();
    bootStartA = 1'b1;
    tick();
    bootStartA = 1'b0;
    checkOutput("start in WRITE ignored", 64'(checksumA), 64'(partSum[1]));
    applyStimulus(1'b1, 26'd1, 1'b0, 1'b0);
    tick();
    checkOutput("fetch during copy valid", 64'(instrValidA), 64'd0);
    for (int s = 0; s < 3; s++) begin
      if (s > 0) tick();
      checkOutput($sformatf("stall%0d we", s),   64'(memWeA),    64'd1);
      checkOutput($sformatf("stall%0d addr", s), 64'(memAddrA),  64'h12);
      checkOutput($sformatf("stall%0d data", s), 64'(memWdataA), 64'(IMG_C));
      checkOutput($sformatf("stall%0d sum", s),  64'(checksumA), 64'(partSum[1]));
    end
    applyStimulus(1'b0, 26'd0, 1'b0, 1'b1);
    tick();
    checkOutput("stall accept we",  64'(memWeA),    64'd0);
    checkOutput("stall accept sum", 64'(checksumA), 64'(partSum[2]));
    tick(); tick();
    checkOutput("recopy done",     64'(bootDoneA), 64'd1);
    checkOutput("recopy checksum", 64'(checksumA), 64'(SUM_ALL));
    checkOutput("recopy accepts",  64'(acceptsA - acceptBase), 64'd4);

    // Reset in the middle of word 2's WRITE.
    bootStartA = 1'b1;
    tick();
    bootStartA = 1'b0;
    tick(); tick(); tick(); tick();
    memReadyA = 1'b0;
    tick();
    checkOutput("pre-reset we",   64'(memWeA),   64'd1);
    checkOutput("pre-reset addr", 64'(memAddrA), 64'h12);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async rst we",   64'(memWeA),    64'd0);
    checkOutput("async rst hold", 64'(cpuHoldA),  64'd1);
    checkOutput("async rst addr", 64'(memAddrA),  64'd0);
    checkOutput("async rst data", 64'(memWdataA), 64'd0);
    checkOutput("async rst sum",  64'(checksumA), 64'd0);
    tick();
    reset = 1'b0;
    memReadyA = 1'b1;
    acceptBase = acceptsA;
    tick();
    checkOutput("restart READ we", 64'(memWeA), 64'd0);
    tick();
    checkOutput("restart w0 addr", 64'(memAddrA),  64'h10);
    checkOutput("restart w0 data", 64'(memWdataA), 64'(IMG_A));
    waitDoneA(20);
    checkOutput("restart checksum", 64'(checksumA), 64'(SUM_ALL));
    checkOutput("restart accepts",  64'(acceptsA - acceptBase), 64'd4);

    // Instance B: manual start, wrapping destination, fetch held off.
    bootStartB = 1'b1;
    tick();
    bootStartB = 1'b0;
    fetchEnB = 1'b1;
    pcB = 4'd1;
    checkOutput("B start hold", 64'(cpuHoldB), 64'd1);
    for (int w = 0; w < 4; w++) begin
      tick();
      checkOutput($sformatf("B write%0d addr", w),  64'(memAddrB),    64'(addrSeqB[w]));
      checkOutput($sformatf("B write%0d we", w),    64'(memWeB),      64'd1);
      checkOutput($sformatf("B write%0d valid", w), 64'(instrValidB), 64'd0);
      tick();
    end
    checkOutput("B done",     64'(bootDoneB), 64'd1);
    checkOutput("B checksum", 64'(checksumB), 64'(SUM_ALL));
    tick();
    checkOutput("B fetch pc1 valid", 64'(instrValidB), 64'd1);
    checkOutput("B fetch pc1 instr", 64'(instrB),      64'(IMG_B));
    pcB = 4'd4;
    tick();
    checkOutput("B fetch pc4 instr", 64'(instrB), 64'(HALT));
    checkOutput("B fetch pc4 oob",   64'(oobB),   64'd1);
    pcB = 4'd15;
    tick();
    checkOutput("B fetch pc15 oob",  64'(oobB),   64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
